// File: rtl/riscv_mc_pkg.sv
// riscv_mc_pkg: shared types and encodings for the multi-cycle RV32I control unit.
//   state_t        FSM state encoding
//   OP_*           major opcodes recognised in DECODE
//   F3_*           branch funct3 values
//   ASEL_/BSEL_/ALU_/IMM_/WB_*  datapath selector encodings
//   CAUSE_*        trap_cause encodings
package riscv_mc_pkg;

    typedef enum logic [3:0] {
        S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_EXEC_I, S_MEM_ADDR, S_MEM_RD,
        S_MEM_WR, S_WB_ALU, S_WB_MEM, S_BRANCH, S_JAL, S_TRAP
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] F3_BEQ = 3'b000;
    localparam logic [2:0] F3_BNE = 3'b001;

    localparam logic [1:0] ASEL_PC    = 2'd0;
    localparam logic [1:0] ASEL_RS1   = 2'd1;
    localparam logic [1:0] ASEL_OLDPC = 2'd2;

    localparam logic [1:0] BSEL_RS2  = 2'd0;
    localparam logic [1:0] BSEL_IMM  = 2'd1;
    localparam logic [1:0] BSEL_FOUR = 2'd2;

    localparam logic [1:0] ALU_ADD   = 2'd0;
    localparam logic [1:0] ALU_SUB   = 2'd1;
    localparam logic [1:0] ALU_FUNCT = 2'd2;

    localparam logic [1:0] IMM_I = 2'd0;
    localparam logic [1:0] IMM_S = 2'd1;
    localparam logic [1:0] IMM_B = 2'd2;
    localparam logic [1:0] IMM_J = 2'd3;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MDR = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] CAUSE_NONE    = 2'd0;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'd1;
    localparam logic [1:0] CAUSE_BUS     = 2'd2;

endpackage

// File: rtl/riscv_mc_perf.sv
// riscv_mc_perf: cycle and retired-instruction counters.
//   clk, reset    core clock, synchronous active-high reset (clears both)
//   count_en      count this cycle in cycle_cnt
//   retire        an instruction retires on this clock edge
//   cycle_cnt     CNT_W-bit wrapping cycle counter
//   instret_cnt   CNT_W-bit wrapping retired-instruction counter
module riscv_mc_perf #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             count_en,
    input  logic             retire,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam logic [CNT_W-1:0] ONE = CNT_W'(1);

    always_ff @(posedge clk) begin
        if (reset) begin
            cycle_cnt   <= '0;
            instret_cnt <= '0;
        end else begin
            if (count_en) cycle_cnt   <= cycle_cnt + ONE;
            if (retire)   instret_cnt <= instret_cnt + ONE;
        end
    end

endmodule

// File: rtl/riscv_mc_ctrl.sv
// riscv_mc_ctrl: multi-cycle RV32I control FSM over a shared memory port.
//   inputs : clk, reset (sync, active-high), opcode/funct3 from IR, ALU zero,
//            mem_ready (memory completes the current request this cycle)
//   outputs: memory handshake (mem_req, mem_we, iord), datapath enables
//            (ir_we, pc_we, pc_src, rf_we), selectors (alu_a_sel, alu_b_sel,
//            alu_op, imm_sel, wb_sel), sticky trap/trap_cause, and the
//            cycle_cnt / instret_cnt performance counters.
module riscv_mc_ctrl
    import riscv_mc_pkg::*;
#(
    parameter int CNT_W   = 32,
    parameter int TIMEOUT = 15,
    parameter bit BNE_EN  = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [6:0]       opcode,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_we,
    output logic             pc_we,
    output logic             pc_src,
    output logic             rf_we,
    output logic [1:0]       alu_a_sel,
    output logic [1:0]       alu_b_sel,
    output logic [1:0]       alu_op,
    output logic [1:0]       imm_sel,
    output logic [1:0]       wb_sel,
    output logic             trap,
    output logic [1:0]       trap_cause,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] instret_cnt
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
    // Trap fires on the stalled cycle that would bring the counter to TIMEOUT.
    localparam logic [WAIT_W-1:0] TO_LAST = WAIT_W'(TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] W_ONE   = WAIT_W'(1);

    state_t            state, state_nxt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [1:0]        cause_nxt;
    logic              retire, is_mem, mem_timeout;

    assign is_mem      = (state == S_FETCH) || (state == S_MEM_RD) || (state == S_MEM_WR);
    assign mem_timeout = !mem_ready && (wait_cnt == TO_LAST);

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            trap_cause <= CAUSE_NONE;
            wait_cnt   <= '0;
        end else begin
            state <= state_nxt;
            if (state_nxt == S_TRAP && state != S_TRAP) trap_cause <= cause_nxt;
            // Staying in a memory state means the request is still stalled;
            // any transition (completion, timeout, entry) restarts the count.
            wait_cnt <= (is_mem && state_nxt == state) ? wait_cnt + W_ONE : '0;
        end
    end

    always_comb begin
        state_nxt = state;
        cause_nxt = CAUSE_NONE;
        retire    = 1'b0;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        iord      = 1'b0;
        ir_we     = 1'b0;
        pc_we     = 1'b0;
        pc_src    = 1'b0;
        rf_we     = 1'b0;
        alu_a_sel = ASEL_PC;
        alu_b_sel = BSEL_RS2;
        alu_op    = ALU_ADD;
        imm_sel   = IMM_I;
        wb_sel    = WB_ALU;
        trap      = 1'b0;
        case (state)
            S_IDLE: state_nxt = S_FETCH;
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_b_sel = BSEL_FOUR;
                if (mem_ready) begin
                    ir_we     = 1'b1;
                    pc_we     = 1'b1;
                    state_nxt = S_DECODE;
                end else if (mem_timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_DECODE: begin
                // Branch target is precomputed here into ALUOut.
                alu_a_sel = ASEL_OLDPC;
                alu_b_sel = BSEL_IMM;
                imm_sel   = IMM_B;
                case (opcode)
                    OP_R:              state_nxt = S_EXEC_R;
                    OP_I:              state_nxt = S_EXEC_I;
                    OP_LOAD, OP_STORE: state_nxt = S_MEM_ADDR;
                    OP_BRANCH:         state_nxt = S_BRANCH;
                    OP_JAL:            state_nxt = S_JAL;
                    default: begin
                        state_nxt = S_TRAP;
                        cause_nxt = CAUSE_ILLEGAL;
                    end
                endcase
            end
            S_EXEC_R: begin
                alu_a_sel = ASEL_RS1;
                alu_op    = ALU_FUNCT;
                state_nxt = S_WB_ALU;
            end
            S_EXEC_I: begin
                alu_a_sel = ASEL_RS1;
                alu_b_sel = BSEL_IMM;
                alu_op    = ALU_FUNCT;
                state_nxt = S_WB_ALU;
            end
            S_MEM_ADDR: begin
                alu_a_sel = ASEL_RS1;
                alu_b_sel = BSEL_IMM;
                imm_sel   = (opcode == OP_STORE) ? IMM_S : IMM_I;
                state_nxt = (opcode == OP_STORE) ? S_MEM_WR : S_MEM_RD;
            end
            S_MEM_RD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    state_nxt = S_WB_MEM;
                end else if (mem_timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_MEM_WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                iord    = 1'b1;
                if (mem_ready) begin
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else if (mem_timeout) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_WB_ALU: begin
                rf_we     = 1'b1;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_WB_MEM: begin
                rf_we     = 1'b1;
                wb_sel    = WB_MDR;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_BRANCH: begin
                alu_a_sel = ASEL_RS1;
                alu_op    = ALU_SUB;
                pc_src    = 1'b1;
                if (funct3 == F3_BEQ || (funct3 == F3_BNE && BNE_EN)) begin
                    pc_we     = (funct3 == F3_BEQ) ? zero : !zero;
                    retire    = 1'b1;
                    state_nxt = S_FETCH;
                end else begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_ILLEGAL;
                end
            end
            S_JAL: begin
                alu_a_sel = ASEL_OLDPC;
                alu_b_sel = BSEL_IMM;
                imm_sel   = IMM_J;
                pc_we     = 1'b1;
                pc_src    = 1'b1;
                rf_we     = 1'b1;
                wb_sel    = WB_PC4;
                retire    = 1'b1;
                state_nxt = S_FETCH;
            end
            S_TRAP:  trap = 1'b1;
            default: state_nxt = S_IDLE;
        endcase
    end

    riscv_mc_perf #(.CNT_W(CNT_W)) u_perf (
        .clk         (clk),
        .reset       (reset),
        .count_en    (state != S_IDLE && state != S_TRAP),
        .retire      (retire),
        .cycle_cnt   (cycle_cnt),
        .instret_cnt (instret_cnt)
    );

endmodule

// File: tb/tb_riscv_mc_ctrl.sv
// tb_riscv_mc_ctrl: directed bench for riscv_mc_ctrl. One instance uses the
// default parameters; a second (CNT_W=4, BNE_EN=0) shares the same stimulus
// and is checked for bne trapping and counter wrap.
module tb_riscv_mc_ctrl;

    localparam logic [6:0] T_OP_R      = 7'b0110011;
    localparam logic [6:0] T_OP_I      = 7'b0010011;
    localparam logic [6:0] T_OP_LOAD   = 7'b0000011;
    localparam logic [6:0] T_OP_STORE  = 7'b0100011;
    localparam logic [6:0] T_OP_BRANCH = 7'b1100011;
    localparam logic [6:0] T_OP_JAL    = 7'b1101111;
    localparam logic [6:0] T_OP_LUI    = 7'b0110111;

    typedef enum int {
        T_IDLE, T_FETCH, T_DECODE, T_EXEC_R, T_EXEC_I, T_MEM_ADDR, T_MEM_RD,
        T_MEM_WR, T_WB_ALU, T_WB_MEM, T_BRANCH, T_JAL, T_TRAP
    } ts_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic [6:0] opcode = 7'd0;
    logic [2:0] funct3 = 3'd0;
    logic zero = 1'b0;
    logic mem_ready = 1'b0;

    logic mem_req, mem_we, iord, ir_we, pc_we, pc_src, rf_we, trap;
    logic [1:0] alu_a_sel, alu_b_sel, alu_op, imm_sel, wb_sel, trap_cause;
    logic [31:0] cycle_cnt, instret_cnt;

    logic mem_req_b, mem_we_b, iord_b, ir_we_b, pc_we_b, pc_src_b, rf_we_b, trap_b;
    logic [1:0] alu_a_sel_b, alu_b_sel_b, alu_op_b, imm_sel_b, wb_sel_b, trap_cause_b;
    logic [3:0] cycle_cnt_b, instret_cnt_b;

    always #5 clk = ~clk;

    riscv_mc_ctrl u_dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req), .mem_we(mem_we), .iord(iord),
        .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src), .rf_we(rf_we),
        .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .alu_op(alu_op),
        .imm_sel(imm_sel), .wb_sel(wb_sel), .trap(trap), .trap_cause(trap_cause),
        .cycle_cnt(cycle_cnt), .instret_cnt(instret_cnt)
    );

    riscv_mc_ctrl #(.CNT_W(4), .TIMEOUT(15), .BNE_EN(1'b0)) u_dut_b (
        .clk(clk), .reset(reset), .opcode(opcode), .funct3(funct3), .zero(zero),
        .mem_ready(mem_ready), .mem_req(mem_req_b), .mem_we(mem_we_b), .iord(iord_b),
        .ir_we(ir_we_b), .pc_we(pc_we_b), .pc_src(pc_src_b), .rf_we(rf_we_b),
        .alu_a_sel(alu_a_sel_b), .alu_b_sel(alu_b_sel_b), .alu_op(alu_op_b),
        .imm_sel(imm_sel_b), .wb_sel(wb_sel_b), .trap(trap_b), .trap_cause(trap_cause_b),
        .cycle_cnt(cycle_cnt_b), .instret_cnt(instret_cnt_b)
    );

    logic [17:0] obs;
    assign obs = {mem_req, mem_we, iord, ir_we, pc_we, pc_src, rf_we,
                  alu_a_sel, alu_b_sel, alu_op, imm_sel, wb_sel, trap};

    logic [17:0] exp_q[$];
    int total = 0;
    int bad = 0;
    int exp_cyc = 0;
    int exp_ret = 0;
    logic [1:0] exp_cause = 2'd0;
    int frozen_b = 0;

    // Expected output vector for one state, straight from the state table.
    function automatic logic [17:0] exp_vec(ts_t s, bit rdy, bit brtake, bit st);
        logic mreq = 0, mwe = 0, io = 0, irw = 0, pcw = 0, pcs = 0, rfw = 0, tr = 0;
        logic [1:0] a = 0, b = 0, op = 0, im = 0, wb = 0;
        case (s)
            T_FETCH:    begin mreq = 1; b = 2; if (rdy) begin irw = 1; pcw = 1; end end
            T_DECODE:   begin a = 2; b = 1; im = 2; end
            T_EXEC_R:   begin a = 1; b = 0; op = 2; end
            T_EXEC_I:   begin a = 1; b = 1; im = 0; op = 2; end
            T_MEM_ADDR: begin a = 1; b = 1; im = st ? 2'd1 : 2'd0; end
            T_MEM_RD:   begin mreq = 1; io = 1; end
            T_MEM_WR:   begin mreq = 1; mwe = 1; io = 1; end
            T_WB_ALU:   begin rfw = 1; wb = 0; end
            T_WB_MEM:   begin rfw = 1; wb = 1; end
            T_BRANCH:   begin a = 1; b = 0; op = 1; pcs = 1; pcw = brtake; end
            T_JAL:      begin a = 2; b = 1; im = 3; pcw = 1; pcs = 1; rfw = 1; wb = 2; end
            T_TRAP:     tr = 1;
            default:    ;
        endcase
        return {mreq, mwe, io, irw, pcw, pcs, rfw, a, b, op, im, wb, tr};
    endfunction

    task automatic chk(string tag, logic [63:0] o, logic [63:0] e);
        total++;
        assert (o === e) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
        end
    endtask

    // One clock cycle: drive mem_ready, queue the expected outputs for the
    // current state, compare at the falling edge, then advance the model.
    task automatic cyc(ts_t s, bit rdy);
        logic [17:0] e;
        bit take, ret;
        mem_ready = rdy;
        take = (funct3 == 3'd0 && zero) || (funct3 == 3'd1 && !zero);
        exp_q.push_back(exp_vec(s, rdy, take, opcode == T_OP_STORE));
        @(negedge clk);
        e = exp_q.pop_front();
        chk($sformatf("out_%s", s.name()), 64'(obs), 64'(e));
        chk($sformatf("cause_%s", s.name()), 64'(trap_cause), 64'(exp_cause));
        chk($sformatf("cycle_cnt_%s", s.name()), 64'(cycle_cnt), 64'(exp_cyc));
        chk($sformatf("instret_%s", s.name()), 64'(instret_cnt), 64'(exp_ret));
        ret = (s == T_WB_ALU) || (s == T_WB_MEM) || (s == T_JAL) ||
              (s == T_MEM_WR && rdy) || (s == T_BRANCH && funct3 <= 3'd1);
        if (reset) begin
            exp_cyc = 0; exp_ret = 0; exp_cause = 2'd0;
        end else begin
            if (s != T_IDLE && s != T_TRAP) exp_cyc++;
            if (ret) exp_ret++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        mem_ready = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_cyc = 0; exp_ret = 0; exp_cause = 2'd0;
        exp_q.delete();
    endtask

    task automatic run_branch(logic [2:0] f3, logic z);
        opcode = T_OP_BRANCH; funct3 = f3; zero = z;
        cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_BRANCH, 1);
    endtask

    initial begin
        do_reset();
        cyc(T_IDLE, 1);

        // R-type, memory always ready
        opcode = T_OP_R; funct3 = 3'd0; zero = 1'b0;
        cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_EXEC_R, 1); cyc(T_WB_ALU, 1);

        // load, 3 stall cycles in MEM_RD
        opcode = T_OP_LOAD;
        cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_MEM_ADDR, 1);
        cyc(T_MEM_RD, 0); cyc(T_MEM_RD, 0); cyc(T_MEM_RD, 0); cyc(T_MEM_RD, 1);
        cyc(T_WB_MEM, 0);

        // store with one stall, then I-type
        opcode = T_OP_STORE;
        cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_MEM_ADDR, 1);
        cyc(T_MEM_WR, 0); cyc(T_MEM_WR, 1);
        opcode = T_OP_I;
        cyc(T_FETCH, 1); cyc(T_DECODE, 0); cyc(T_EXEC_I, 0); cyc(T_WB_ALU, 0);

        // branches
        run_branch(3'd0, 1'b1);
        run_branch(3'd0, 1'b0);
        run_branch(3'd1, 1'b1);
        chk("b_bne_trap", 64'(trap_b), 64'd1);
        chk("b_bne_cause", 64'(trap_cause_b), 64'd1);
        frozen_b = exp_ret - 1;
        chk("b_instret_at_trap", 64'(instret_cnt_b), 64'(4'(frozen_b)));
        run_branch(3'd1, 1'b0);

        opcode = T_OP_JAL; funct3 = 3'd0;
        cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_JAL, 1);

        // unsupported opcode traps from DECODE, counters freeze
        opcode = T_OP_LUI;
        cyc(T_FETCH, 1); cyc(T_DECODE, 1);
        exp_cause = 2'd1;
        cyc(T_TRAP, 1); cyc(T_TRAP, 0); cyc(T_TRAP, 1);
        chk("b_trap_sticky", 64'(trap_b), 64'd1);
        chk("b_instret_frozen", 64'(instret_cnt_b), 64'(4'(frozen_b)));

        // fetch timeout: 15 stalled cycles
        do_reset();
        cyc(T_IDLE, 0);
        for (int i = 0; i < 15; i++) cyc(T_FETCH, 0);
        exp_cause = 2'd2;
        cyc(T_TRAP, 0); cyc(T_TRAP, 1);

        // ready exactly on the 15th cycle wins
        do_reset();
        opcode = T_OP_R;
        cyc(T_IDLE, 0);
        for (int i = 0; i < 14; i++) cyc(T_FETCH, 0);
        cyc(T_FETCH, 1); cyc(T_DECODE, 0); cyc(T_EXEC_R, 0); cyc(T_WB_ALU, 0);

        // reset in the middle of a stalled store
        opcode = T_OP_STORE;
        cyc(T_FETCH, 1); cyc(T_DECODE, 0); cyc(T_MEM_ADDR, 0);
        cyc(T_MEM_WR, 0);
        reset = 1'b1;
        cyc(T_MEM_WR, 0);
        reset = 1'b0;
        cyc(T_IDLE, 0);

        // illegal branch funct3
        opcode = T_OP_BRANCH; funct3 = 3'd2; zero = 1'b1;
        cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_BRANCH, 1);
        exp_cause = 2'd1;
        cyc(T_TRAP, 1);

        // 16 retirements: the 4-bit counters wrap to 0
        do_reset();
        cyc(T_IDLE, 1);
        opcode = T_OP_JAL; funct3 = 3'd0;
        for (int i = 0; i < 16; i++) begin
            cyc(T_FETCH, 1); cyc(T_DECODE, 1); cyc(T_JAL, 1);
        end
        opcode = T_OP_R;
        cyc(T_FETCH, 1);
        chk("b_instret_wrap", 64'(instret_cnt_b), 64'(4'(exp_ret)));
        chk("b_instret_zero", 64'(instret_cnt_b), 64'd1 - 64'd1);
        chk("b_cycle_wrap", 64'(cycle_cnt_b), 64'(4'(exp_cyc)));
        chk("b_no_trap", 64'(trap_b), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule
